// File: rtl/handshake_pkg.sv
// Shared constants and sizing helpers for the handshake buffer family.
package handshake_pkg;

   localparam int DEFAULT_WIDTH = 4;
   localparam int DEFAULT_DEPTH = 4;

   function automatic int ptr_width(input int depth);
      return $clog2(depth);
   endfunction

   function automatic int count_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   // Kept for users of the older single-register handshake block
   typedef logic [$clog2(DEFAULT_DEPTH + 1)-1:0] count_t;

endpackage

// File: rtl/handshake_ptr.sv
// Wrapping pointer register; rolls over through natural binary overflow.
module handshake_ptr #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] value
);

   always_ff @(posedge clk) begin
      if (rst || clr)
         value <= '0;
      else if (en)
         value <= value + W'(1);
   end

endmodule

// File: rtl/handshake_fifo.sv
// Valid/ready FIFO with first-word fall-through, fill count and synchronous flush.
module handshake_fifo
   import handshake_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int DEPTH = DEFAULT_DEPTH
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic [WIDTH-1:0]             data_in,
   input  logic                         valid_in,
   output logic                         ready_out,
   output logic [WIDTH-1:0]             data_out,
   output logic                         valid_out,
   input  logic                         ready_in,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int PW = ptr_width(DEPTH);
   localparam int CW = count_width(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             full;
   logic             empty;
   logic             push;
   logic             pop;

   // ready_out depends only on registered state and rst, never on ready_in
   assign full      = (count == CW'(DEPTH));
   assign empty     = (count == '0);
   assign ready_out = !full && !rst;
   assign valid_out = !empty;
   assign data_out  = empty ? '0 : mem[rd_ptr];
   assign push      = valid_in && ready_out;
   assign pop       = valid_out && ready_in;

   handshake_ptr #(.W(PW)) u_wr_ptr (
      .clk   (clk),
      .rst   (rst),
      .clr   (flush),
      .en    (push),
      .value (wr_ptr)
   );

   handshake_ptr #(.W(PW)) u_rd_ptr (
      .clk   (clk),
      .rst   (rst),
      .clr   (flush),
      .en    (pop),
      .value (rd_ptr)
   );

   always_ff @(posedge clk) begin
      if (push && !flush)
         mem[wr_ptr] <= data_in;
   end

   always_ff @(posedge clk) begin
      if (rst || flush)
         count <= '0;
      else begin
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule
